// File: rtl/cpu_types_pkg.sv
// Shared types for the EX/MEM pipeline boundary: request FSM states and the
// latched EX/MEM field bundle with its bubble value.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic        memtoReg;
        logic        memWr;
        logic        RegWr;
        logic        halt;
        logic [4:0]  final_wsel;
        logic [31:0] aluout;
        logic [31:0] storedata;
        logic [31:0] next_addr;
        logic [31:0] imemaddr;
        logic [31:0] instr;
    } exmem_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // A bubble carries no controls and a nop instruction word.
    localparam exmem_t EXMEM_BUBBLE = '{instr: NOP_INSTR, default: '0};

endpackage

// File: rtl/execute_memory_if.sv
// Carrier for the registered EX/MEM fields; the stage drives it, observers read it.
interface execute_memory_if;
    import cpu_types_pkg::*;

    exmem_t q;

    modport exmem (output q);
    modport tb    (input  q);

endinterface

// File: rtl/dmem_req_fsm.sv
// Data-memory request sequencer for the MEM stage: IDLE -> REQ -> DONE, with a
// sticky halt that blocks any further request until reset.
module dmem_req_fsm
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       enable,
    input  logic       flush,
    input  logic       mem_op_EX,
    input  logic       halt_EX,
    input  logic       dhit,
    output mem_state_t state,
    output logic       advance,
    output logic       load_done,
    output logic       mem_stall
);

    mem_state_t state_q, state_next;
    logic       halted_q, halted_next;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_next;
            halted_q <= halted_next;
        end
    end

    always_comb begin
        state_next  = state_q;
        halted_next = halted_q;
        // An outstanding access can only be left on its hit; enable waits for it.
        advance   = enable && ((state_q != REQ) || dhit);
        load_done = (state_q == REQ) && dhit;
        mem_stall = (state_q == REQ) && !dhit;

        if (advance) begin
            if (!flush && mem_op_EX && !halt_EX && !halted_q) begin
                state_next = REQ;
            end else begin
                state_next = IDLE;
            end
            if (!flush && halt_EX) begin
                halted_next = 1'b1;
            end
        end else if (load_done) begin
            state_next = DONE;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/execute_memory.sv
// EX/MEM pipeline register with data-memory request handling.
// Optional build macro EXMEM_PERF_EN adds the stall_count performance counter.
module execute_memory
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable,
    input  logic        flush,
    input  logic        memtoReg_EX,
    input  logic        memWr_EX,
    input  logic        RegWr_EX,
    input  logic        halt_EX,
    input  logic [4:0]  final_wsel_EX,
    input  logic [31:0] aluout_EX,
    input  logic [31:0] storedata_EX,
    input  logic [31:0] next_addr_EX,
    input  logic [31:0] imemaddr_EX,
    input  logic [31:0] instr_EX,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        memtoReg_MEM,
    output logic        memWr_MEM,
    output logic        RegWr_MEM,
    output logic        halt_MEM,
    output logic [4:0]  final_wsel_MEM,
    output logic [31:0] aluout_MEM,
    output logic [31:0] storedata_MEM,
    output logic [31:0] next_addr_MEM,
    output logic [31:0] imemaddr_MEM,
    output logic [31:0] instr_MEM,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
`ifdef EXMEM_PERF_EN
    output logic [31:0] stall_count,
`endif
    output mem_state_t  fsm_state
);

    execute_memory_if exmem_bus ();

    exmem_t     ex_fields;
    logic       advance;
    logic       load_done;
    logic [31:0] load_data_MEM;

    assign ex_fields = '{
        memtoReg:   memtoReg_EX,
        memWr:      memWr_EX,
        RegWr:      RegWr_EX,
        halt:       halt_EX,
        final_wsel: final_wsel_EX,
        aluout:     aluout_EX,
        storedata:  storedata_EX,
        next_addr:  next_addr_EX,
        imemaddr:   imemaddr_EX,
        instr:      instr_EX
    };

    dmem_req_fsm u_fsm (
        .CLK       (CLK),
        .RST       (RST),
        .enable    (enable),
        .flush     (flush),
        .mem_op_EX (memtoReg_EX | memWr_EX),
        .halt_EX   (halt_EX),
        .dhit      (dhit),
        .state     (fsm_state),
        .advance   (advance),
        .load_done (load_done),
        .mem_stall (mem_stall)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            exmem_bus.q <= '0;
        end else if (advance) begin
            exmem_bus.q <= flush ? EXMEM_BUBBLE : ex_fields;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            load_data_MEM <= '0;
        end else if (load_done) begin
            load_data_MEM <= dmemload;
        end
    end

`ifdef EXMEM_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_count <= '0;
        end else if (mem_stall && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

    assign memtoReg_MEM   = exmem_bus.q.memtoReg;
    assign memWr_MEM      = exmem_bus.q.memWr;
    assign RegWr_MEM      = exmem_bus.q.RegWr;
    assign halt_MEM       = exmem_bus.q.halt;
    assign final_wsel_MEM = exmem_bus.q.final_wsel;
    assign aluout_MEM     = exmem_bus.q.aluout;
    assign storedata_MEM  = exmem_bus.q.storedata;
    assign next_addr_MEM  = exmem_bus.q.next_addr;
    assign imemaddr_MEM   = exmem_bus.q.imemaddr;
    assign instr_MEM      = exmem_bus.q.instr;

    // Strobes qualify on REQ only; address and data follow the registers always.
    assign dmemREN   = (fsm_state == REQ) && exmem_bus.q.memtoReg;
    assign dmemWEN   = (fsm_state == REQ) && exmem_bus.q.memWr;
    assign dmemaddr  = exmem_bus.q.aluout;
    assign dmemstore = exmem_bus.q.storedata;

    assign mem_rdata = load_done ? dmemload : load_data_MEM;

endmodule

// File: tb/tb_execute_memory.sv
// Self-checking bench for execute_memory: directed scenarios plus a
// back-to-back load sequence scored against an expected-data queue.
module tb_execute_memory;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        enable, flush;
    logic        memtoReg_EX, memWr_EX, RegWr_EX, halt_EX;
    logic [4:0]  final_wsel_EX;
    logic [31:0] aluout_EX, storedata_EX, next_addr_EX, imemaddr_EX, instr_EX;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore;
    logic        memtoReg_MEM, memWr_MEM, RegWr_MEM, halt_MEM;
    logic [4:0]  final_wsel_MEM;
    logic [31:0] aluout_MEM, storedata_MEM, next_addr_MEM, imemaddr_MEM, instr_MEM;
    logic [31:0] mem_rdata;
    logic        mem_stall;
`ifdef EXMEM_PERF_EN
    logic [31:0] stall_count;
`endif
    mem_state_t  fsm_state;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    execute_memory dut (
        .CLK(CLK), .RST(RST), .enable(enable), .flush(flush),
        .memtoReg_EX(memtoReg_EX), .memWr_EX(memWr_EX), .RegWr_EX(RegWr_EX), .halt_EX(halt_EX),
        .final_wsel_EX(final_wsel_EX), .aluout_EX(aluout_EX), .storedata_EX(storedata_EX),
        .next_addr_EX(next_addr_EX), .imemaddr_EX(imemaddr_EX), .instr_EX(instr_EX),
        .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .memtoReg_MEM(memtoReg_MEM), .memWr_MEM(memWr_MEM), .RegWr_MEM(RegWr_MEM), .halt_MEM(halt_MEM),
        .final_wsel_MEM(final_wsel_MEM), .aluout_MEM(aluout_MEM), .storedata_MEM(storedata_MEM),
        .next_addr_MEM(next_addr_MEM), .imemaddr_MEM(imemaddr_MEM), .instr_MEM(instr_MEM),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall),
`ifdef EXMEM_PERF_EN
        .stall_count(stall_count),
`endif
        .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_ex();
        enable = 0; flush = 0;
        memtoReg_EX = 0; memWr_EX = 0; RegWr_EX = 0; halt_EX = 0;
        final_wsel_EX = '0; aluout_EX = '0; storedata_EX = '0;
        next_addr_EX = '0; imemaddr_EX = '0; instr_EX = '0;
        dhit = 0; dmemload = '0;
    endtask

    task automatic drive_load(input logic [31:0] addr, input logic [31:0] instr);
        memtoReg_EX = 1; memWr_EX = 0; RegWr_EX = 1; halt_EX = 0;
        aluout_EX = addr; instr_EX = instr; enable = 1;
    endtask

    task automatic test_reset();
        clear_ex();
        RST = 1;
        step();
        #1;
        checks++;
        if ({dmemREN, dmemWEN, mem_stall} !== 3'b000) begin
            errors++; $display("FAIL reset_req: got %b required 000", {dmemREN, dmemWEN, mem_stall});
        end
        checks++;
        if (fsm_state !== IDLE) begin
            errors++; $display("FAIL reset_state: got %0d required %0d", fsm_state, IDLE);
        end
        checks++;
        if ({mem_rdata, aluout_MEM, instr_MEM, RegWr_MEM} !== 97'd0) begin
            errors++; $display("FAIL reset_regs: rdata=%h aluout=%h instr=%h required 0", mem_rdata, aluout_MEM, instr_MEM);
        end
        RST = 0;
        step();
    endtask

    task automatic test_load();
        int ren_cycles = 0;
        int stall_cycles = 0;
        logic [31:0] exp;
        clear_ex();
        drive_load(32'h0000_0100, 32'h8C01_0100);
        final_wsel_EX = 5'd9; next_addr_EX = 32'h44; imemaddr_EX = 32'h40;
        exp_q.push_back(32'hDEAD_BEEF);
        step();
        clear_ex();
        #1;
        checks++;
        if ({final_wsel_MEM, next_addr_MEM, imemaddr_MEM, instr_MEM} !== {5'd9, 32'h44, 32'h40, 32'h8C01_0100}) begin
            errors++; $display("FAIL load_capture: wsel=%0d next=%h imem=%h instr=%h", final_wsel_MEM, next_addr_MEM, imemaddr_MEM, instr_MEM);
        end
        for (int c = 0; c < 4; c++) begin
            dhit = (c == 3);
            dmemload = (c == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
            #1;
            if (dmemREN) ren_cycles++;
            if (mem_stall) stall_cycles++;
            if (c == 0) begin
                checks++;
                if ({dmemaddr, dmemWEN} !== {32'h100, 1'b0}) begin
                    errors++; $display("FAIL load_addr: got %h wen=%b required 00000100 wen=0", dmemaddr, dmemWEN);
                end
            end
            if (dhit) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
                checks++;
                if (mem_rdata !== exp) begin
                    errors++; $display("FAIL load_rdata_hit: got %h required %h", mem_rdata, exp);
                end
            end
            step();
        end
        dhit = 0; dmemload = 32'h0;
        #1;
        checks++;
        if (ren_cycles != 4 || stall_cycles != 3) begin
            errors++; $display("FAIL load_cycles: ren=%0d stall=%0d required 4 and 3", ren_cycles, stall_cycles);
        end
        checks++;
        if (fsm_state !== DONE || dmemREN !== 1'b0) begin
            errors++; $display("FAIL load_done: state=%0d ren=%b required %0d ren=0", fsm_state, dmemREN, DONE);
        end
        checks++;
        if (mem_rdata !== 32'hDEAD_BEEF || dmemaddr !== 32'h100) begin
            errors++; $display("FAIL load_hold: rdata=%h addr=%h required deadbeef 00000100", mem_rdata, dmemaddr);
        end
    endtask

    task automatic test_store();
        int wen_pulses = 0;
        int ren_seen = 0;
        logic [31:0] store_seen = '0;
        clear_ex();
        memWr_EX = 1; storedata_EX = 32'h1234_5678; aluout_EX = 32'h200; enable = 1;
        step();
        clear_ex();
        for (int c = 0; c < 3; c++) begin
            dhit = (c == 0);
            #1;
            if (dmemWEN) begin
                wen_pulses++;
                store_seen = dmemstore;
            end
            if (dmemREN) ren_seen++;
            step();
        end
        dhit = 0;
        checks++;
        if (wen_pulses != 1 || store_seen !== 32'h1234_5678) begin
            errors++; $display("FAIL store_wen: pulses=%0d data=%h required 1 12345678", wen_pulses, store_seen);
        end
        checks++;
        if (ren_seen != 0) begin
            errors++; $display("FAIL store_ren: ren cycles=%0d required 0", ren_seen);
        end
        checks++;
        if (fsm_state !== DONE || memWr_MEM !== 1'b1 || storedata_MEM !== 32'h1234_5678) begin
            errors++; $display("FAIL store_state: state=%0d memWr=%b sd=%h", fsm_state, memWr_MEM, storedata_MEM);
        end
    endtask

    task automatic test_flush();
        clear_ex();
        memtoReg_EX = 1; memWr_EX = 1; RegWr_EX = 1; halt_EX = 1; final_wsel_EX = 5'h1F;
        aluout_EX = 32'h400; storedata_EX = 32'h5555_AAAA; next_addr_EX = 32'h8;
        imemaddr_EX = 32'h4; instr_EX = 32'hFFFF_FFFF;
        flush = 1; enable = 1;
        step();
        clear_ex();
        #1;
        checks++;
        if (instr_MEM !== 32'h0 || RegWr_MEM !== 1'b0) begin
            errors++; $display("FAIL flush_instr: instr=%h RegWr=%b required 0 0", instr_MEM, RegWr_MEM);
        end
        checks++;
        if ({memtoReg_MEM, memWr_MEM, halt_MEM, final_wsel_MEM, aluout_MEM, storedata_MEM, next_addr_MEM, imemaddr_MEM} !== '0) begin
            errors++; $display("FAIL flush_fields: aluout=%h sd=%h halt=%b required all 0", aluout_MEM, storedata_MEM, halt_MEM);
        end
        checks++;
        if (fsm_state !== IDLE || dmemREN !== 1'b0 || dmemWEN !== 1'b0) begin
            errors++; $display("FAIL flush_state: state=%0d ren=%b wen=%b required IDLE 0 0", fsm_state, dmemREN, dmemWEN);
        end
    endtask

    task automatic test_hold_in_req();
        logic [31:0] exp;
        clear_ex();
        drive_load(32'h300, 32'h1111_1111);
        exp_q.push_back(32'hCAFE_F00D);
        step();
        for (int c = 0; c < 2; c++) begin
            clear_ex();
            memWr_EX = 1; aluout_EX = 32'h999; instr_EX = 32'h2222_2222;
            enable = 1; flush = (c == 0);
            #1;
            checks++;
            if (dmemREN !== 1'b1 || mem_stall !== 1'b1) begin
                errors++; $display("FAIL hold_req: ren=%b stall=%b required 1 1", dmemREN, mem_stall);
            end
            step();
            checks++;
            if (aluout_MEM !== 32'h300 || instr_MEM !== 32'h1111_1111 || fsm_state !== REQ) begin
                errors++; $display("FAIL hold_regs: aluout=%h instr=%h state=%0d required 300 11111111 REQ", aluout_MEM, instr_MEM, fsm_state);
            end
        end
        clear_ex();
        dhit = 1; dmemload = 32'hCAFE_F00D;
        #1;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        checks++;
        if (mem_rdata !== exp) begin
            errors++; $display("FAIL hold_rdata: got %h required %h", mem_rdata, exp);
        end
        step();
        dhit = 0;
    endtask

    task automatic test_reset_mid_req();
        clear_ex();
        drive_load(32'h500, 32'h3333_3333);
        step();
        clear_ex();
        #1;
        checks++;
        if (dmemREN !== 1'b1) begin
            errors++; $display("FAIL midreset_pre: ren=%b required 1", dmemREN);
        end
        #2;
        RST = 1;
        #1;
        checks++;
        if (dmemREN !== 1'b0 || fsm_state !== IDLE) begin
            errors++; $display("FAIL midreset_drop: ren=%b state=%0d required 0 IDLE", dmemREN, fsm_state);
        end
        RST = 0;
        step();
        checks++;
        if (fsm_state !== IDLE || mem_rdata !== 32'h0 || aluout_MEM !== 32'h0) begin
            errors++; $display("FAIL midreset_after: state=%0d rdata=%h aluout=%h required IDLE 0 0", fsm_state, mem_rdata, aluout_MEM);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 6;
        logic [31:0] addr [N];
        logic [31:0] data [N];
        logic [31:0] exp, next_exp_addr;
        int lat;
        for (int i = 0; i < N; i++) begin
            addr[i] = {$urandom_range(0, 32'hFFFF), 2'b00} + 32'h1000;
            data[i] = $urandom;
        end
        clear_ex();
        drive_load(addr[0], 32'h8C00_0000);
        exp_q.push_back(data[0]);
        step();
        for (int i = 0; i < N; i++) begin
            lat = $urandom_range(0, 3);
            clear_ex();
            if (i < N - 1) begin
                drive_load(addr[i+1], 32'h8C00_0000 + i + 1);
                next_exp_addr = addr[i+1];
            end else begin
                RegWr_EX = 1; aluout_EX = 32'hABC; enable = 1;
                next_exp_addr = 32'hABC;
            end
            for (int w = 0; w < lat; w++) begin
                #1;
                checks++;
                if (mem_stall !== 1'b1 || aluout_MEM !== addr[i]) begin
                    errors++; $display("FAIL b2b_wait[%0d]: stall=%b aluout=%h required 1 %h", i, mem_stall, aluout_MEM, addr[i]);
                end
                step();
            end
            dhit = 1; dmemload = data[i];
            if (i < N - 1) exp_q.push_back(data[i+1]);
            #1;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
            checks++;
            if (mem_rdata !== exp || mem_stall !== 1'b0) begin
                errors++; $display("FAIL b2b_rdata[%0d]: got %h stall=%b required %h 0", i, mem_rdata, mem_stall, exp);
            end
            step();
            dhit = 0;
            checks++;
            if (aluout_MEM !== next_exp_addr || fsm_state !== ((i < N - 1) ? REQ : IDLE)) begin
                errors++; $display("FAIL b2b_adv[%0d]: aluout=%h state=%0d required %h", i, aluout_MEM, fsm_state, next_exp_addr);
            end
        end
        clear_ex();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_queue: %0d entries left required 0", exp_q.size());
        end
    endtask

    task automatic test_halt();
        clear_ex();
        halt_EX = 1; enable = 1;
        step();
        clear_ex();
        checks++;
        if (halt_MEM !== 1'b1 || fsm_state !== IDLE) begin
            errors++; $display("FAIL halt_capture: halt=%b state=%0d required 1 IDLE", halt_MEM, fsm_state);
        end
        for (int c = 0; c < 2; c++) begin
            drive_load(32'h600 + c, 32'h8C00_0600);
            step();
            checks++;
            if (aluout_MEM !== 32'h600 + c || fsm_state !== IDLE || dmemREN !== 1'b0) begin
                errors++; $display("FAIL halt_block[%0d]: aluout=%h state=%0d ren=%b required IDLE ren=0", c, aluout_MEM, fsm_state, dmemREN);
            end
        end
        clear_ex();
        RST = 1;
        #2;
        RST = 0;
        step();
        drive_load(32'h700, 32'h8C00_0700);
        step();
        clear_ex();
        checks++;
        if (fsm_state !== REQ || dmemREN !== 1'b1) begin
            errors++; $display("FAIL halt_cleared: state=%0d ren=%b required REQ 1", fsm_state, dmemREN);
        end
        dhit = 1; dmemload = 32'h7;
        step();
        dhit = 0;
    endtask

`ifdef EXMEM_PERF_EN
    task automatic test_perf();
        clear_ex();
        RST = 1;
        #2;
        RST = 0;
        step();
        checks++;
        if (stall_count !== 32'd0) begin
            errors++; $display("FAIL perf_reset: got %0d required 0", stall_count);
        end
        for (int t = 0; t < 2; t++) begin
            drive_load(32'h800 + 4 * t, 32'h8C00_0800);
            step();
            clear_ex();
            for (int c = 0; c < 4; c++) begin
                dhit = (c == 3);
                step();
            end
            dhit = 0;
        end
        checks++;
        if (stall_count !== 32'd6) begin
            errors++; $display("FAIL perf_count: got %0d required 6", stall_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_store();
        test_flush();
        test_hold_in_req();
        test_reset_mid_req();
        test_back_to_back();
        test_halt();
`ifdef EXMEM_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
